pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameters, one per line (name, default, meaning):
  AW, 5, register-address width.
  POST, 3, tracked post-decode slots; slot 0=EX, 1=MEM, POST-1=WB; legal 2..8.
  LOAD_LAT, 1, load-use stall distance in slots; legal 1..POST-1.
  CW, 16, statistics counter width.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high. Ports are Clk and Reset.
REQ-003 Ports, one per line (name, direction, width, meaning):
  Clk  in  1  clock.
  Reset  in  1  sync active-high reset.
  id_valid  in  1  ID holds a live instruction.
  id_rs, id_rt  in  AW  ID source registers.
  id_use_rs, id_use_rt  in  1  source is actually read.
  id_dst  in  AW  ID destination (post-RegDst).
  id_regwrite, id_memread  in  1  ID control bits.
  ex_redirect  in  1  branch/jump resolved taken in EX.
  stall_if, stall_id  out  1  hold PC and IF/ID.
  flush_id  out  1  invalidate IF/ID next edge.
  bubble_ex  out  1  ID/EX loads a bubble next edge.
  fwd_a, fwd_b  out  $clog2(POST)  EX operand source; 0=regfile, k=slot k.
  slot_valid  out  POST  valid bit per slot.
  stall_cnt, flush_cnt  out  CW  saturating event counters.

Function
REQ-004 Shadow slots SHALL each hold {valid, rs, rt, use_rs, use_rt, dst, regwrite, memread}.
REQ-005 Each edge: slot k SHALL take slot k-1 for k>=1; slot 0 SHALL take ID fields with valid=id_valid, or valid=0 when bubble_ex=1.
REQ-006 Load hazard SHALL be: id_valid, and some slot j<LOAD_LAT with valid, memread, regwrite, dst!=0, dst equal to a used ID source.
REQ-007 On load hazard without redirect: stall_if=stall_id=bubble_ex=1, flush_id=0; combinational, same cycle.
REQ-008 On ex_redirect: flush_id=bubble_ex=1, stall_if=stall_id=0; redirect SHALL override load hazard.
REQ-009 With neither condition, all four control outputs SHALL be 0.
REQ-010 fwd_a SHALL be the smallest k in 1..POST-1 where slot k is valid, regwrite, dst!=0, dst==slot0.rs, and slot0 is valid with use_rs; else 0. fwd_b likewise for rt.
REQ-011 Loads SHALL be forwarding sources only from slots >= LOAD_LAT.
REQ-012 Register 0 SHALL never cause a stall or a forward.
REQ-013 stall_cnt SHALL increment each cycle REQ-007 applies; flush_cnt each cycle ex_redirect=1. Both SHALL saturate at all-ones, not wrap.
REQ-014 Forwarding and stall outputs SHALL be combinational from slots and ID inputs. Slot and counter updates SHALL have one-cycle latency.

Reset
REQ-015 While Reset=1 at an edge: all slot valid bits, stall_cnt and flush_cnt SHALL clear to 0. Reset mid-stall discards the hazard.
REQ-016 During and after reset, with id_valid=0 and ex_redirect=0: stall_if, stall_id, flush_id, bubble_ex, fwd_a, fwd_b SHALL be 0.
REQ-017 Reset SHALL take priority over every other input on the same edge.

Structure
REQ-018 Shared package/include pipe_pkg SHALL define FWD_RF=0, slot indices SLOT_EX=0, SLOT_MEM=1, SLOT_WB=2, and the slot-record field layout.
REQ-019 One sub-module, fwd_match, SHALL compare a source register against all slots and return the priority-encoded fwd index. It SHALL be instantiated twice (rs, rt).

Verification
REQ-020 Defaults:
  - lw r2 (slot0) then ID add r3,r2,r4: one cycle with stall_if=stall_id=bubble_ex=1.
  - Next cycle stall=0.
  - When add reaches EX: fwd_a=2.
REQ-021 ID add r5 after add r5 in slot 0 and sub r5 in slot 1:
  - No stall.
  - When dependent in EX: fwd_a=1 (youngest wins).
REQ-022 Same-cycle load hazard and ex_redirect=1: flush_id=1, bubble_ex=1, stall_if=0, stall_cnt unchanged, flush_cnt+1.
REQ-023 Writes and reads of r0 (lw r0 then use r0): no stall, fwd_a=fwd_b=0.
REQ-024 POST=5, LOAD_LAT=2: load in slot 1 matching ID source stalls. With CW=4, 20 stall cycles leave stall_cnt=15.
REQ-025 Reset asserted during a stall: next cycle slot_valid=0, counters=0, stall outputs=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants for the pipeline hazard controller.
//   FWD_RF          forwarding index meaning "take operand from the register file"
//   SLOT_EX/MEM/WB  slot indices of the post-decode shadow pipeline
//   F_*             bit positions of the flag fields inside a packed slot record
//   slot_w/f_rs/f_rt  record width and register-field offsets for a given address width
// Slot record layout (LSB first): valid, regwrite, memread, use_rs, use_rt, dst, rs, rt.
package pipe_pkg;

    localparam int FWD_RF   = 0;

    localparam int SLOT_EX  = 0;
    localparam int SLOT_MEM = 1;
    localparam int SLOT_WB  = 2;

    localparam int F_VALID    = 0;
    localparam int F_REGWRITE = 1;
    localparam int F_MEMREAD  = 2;
    localparam int F_USE_RS   = 3;
    localparam int F_USE_RT   = 4;
    localparam int F_DST      = 5;

    function automatic int slot_w(input int aw);
        return F_DST + 3 * aw;
    endfunction

    function automatic int f_rs(input int aw);
        return F_DST + aw;
    endfunction

    function automatic int f_rt(input int aw);
        return F_DST + 2 * aw;
    endfunction

endpackage

// File: rtl/fwd_match.sv
// fwd_match: compares one EX source register against every older slot and
// returns the index of the youngest eligible producer (FWD_RF when none).
// Ports:
//   src_i       source register of the instruction in EX
//   src_en_i    EX slot is valid and actually reads this source
//   valid_i     per-slot valid
//   regwrite_i  per-slot regwrite
//   memread_i   per-slot memread (loads only eligible from slot LOAD_LAT on)
//   dst_i       per-slot destination, slot k at [k*AW +: AW]
//   fwd_o       priority-encoded forwarding index
module fwd_match
    import pipe_pkg::*;
#(
    parameter int AW       = 5,
    parameter int POST     = 3,
    parameter int LOAD_LAT = 1,
    parameter int FW       = $clog2(POST)
) (
    input  logic [AW-1:0]      src_i,
    input  logic               src_en_i,
    input  logic [POST-1:0]    valid_i,
    input  logic [POST-1:0]    regwrite_i,
    input  logic [POST-1:0]    memread_i,
    input  logic [POST*AW-1:0] dst_i,
    output logic [FW-1:0]      fwd_o
);

    // Scan oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        fwd_o = FW'(FWD_RF);
        for (int k = POST - 1; k >= 1; k--) begin
            if (src_en_i && valid_i[k] && regwrite_i[k] &&
                (!memread_i[k] || k >= LOAD_LAT) &&
                (dst_i[k*AW +: AW] != '0) && (dst_i[k*AW +: AW] == src_i)) begin
                fwd_o = FW'(k);
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use stall, redirect flush and operand forwarding
// control for an in-order pipeline. A shadow copy of the post-decode stages
// (slot 0 = EX ... slot POST-1 = WB) is kept here so hazard decisions need
// no feedback from the datapath.
// Ports:
//   Clk, Reset                    clock, synchronous active-high reset
//   id_valid, id_rs/rt, id_use_*  instruction in ID and which sources it reads
//   id_dst, id_regwrite/memread   ID destination and control bits
//   ex_redirect                   taken branch/jump resolved in EX
//   stall_if/stall_id/flush_id/bubble_ex  pipeline control, combinational
//   fwd_a/fwd_b                   EX operand source (0 = regfile, k = slot k)
//   slot_valid                    valid bit per shadow slot
//   stall_cnt/flush_cnt           saturating event counters
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int AW       = 5,
    parameter int POST     = 3,
    parameter int LOAD_LAT = 1,
    parameter int CW       = 16
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    id_valid,
    input  logic [AW-1:0]           id_rs,
    input  logic [AW-1:0]           id_rt,
    input  logic                    id_use_rs,
    input  logic                    id_use_rt,
    input  logic [AW-1:0]           id_dst,
    input  logic                    id_regwrite,
    input  logic                    id_memread,
    input  logic                    ex_redirect,
    output logic                    stall_if,
    output logic                    stall_id,
    output logic                    flush_id,
    output logic                    bubble_ex,
    output logic [$clog2(POST)-1:0] fwd_a,
    output logic [$clog2(POST)-1:0] fwd_b,
    output logic [POST-1:0]         slot_valid,
    output logic [CW-1:0]           stall_cnt,
    output logic [CW-1:0]           flush_cnt
);

    localparam int SW   = slot_w(AW);
    localparam int RS_L = f_rs(AW);
    localparam int RT_L = f_rt(AW);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [POST-1:0][SW-1:0] slot_q, slot_d;
    logic [CW-1:0]           stall_cnt_q, stall_cnt_d;
    logic [CW-1:0]           flush_cnt_q, flush_cnt_d;

    logic [POST-1:0]         sv_valid, sv_regwrite, sv_memread;
    logic [POST*AW-1:0]      sv_dst;
    logic                    load_hit, load_haz, stall_ev;

    // The WB slot's source fields are carried only for uniformity of the record.
    logic                    unused_tail;
    assign unused_tail = ^slot_q[POST-1];

    always_comb begin
        sv_valid    = '0;
        sv_regwrite = '0;
        sv_memread  = '0;
        sv_dst      = '0;
        for (int k = 0; k < POST; k++) begin
            sv_valid[k]          = slot_q[k][F_VALID];
            sv_regwrite[k]       = slot_q[k][F_REGWRITE];
            sv_memread[k]        = slot_q[k][F_MEMREAD];
            sv_dst[k*AW +: AW]   = slot_q[k][F_DST +: AW];
        end
    end

    // A load that has not yet produced its data (slots below LOAD_LAT)
    // and writes a register the ID instruction reads forces a stall.
    always_comb begin
        load_hit = 1'b0;
        for (int j = 0; j < LOAD_LAT; j++) begin
            if (slot_q[j][F_VALID] && slot_q[j][F_MEMREAD] && slot_q[j][F_REGWRITE] &&
                (slot_q[j][F_DST +: AW] != '0) &&
                ((id_use_rs && (slot_q[j][F_DST +: AW] == id_rs)) ||
                 (id_use_rt && (slot_q[j][F_DST +: AW] == id_rt)))) begin
                load_hit = 1'b1;
            end
        end
        load_haz = id_valid && load_hit;
    end

    // Redirect wins: the ID instruction is on the wrong path anyway.
    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        flush_id  = 1'b0;
        bubble_ex = 1'b0;
        if (ex_redirect) begin
            flush_id  = 1'b1;
            bubble_ex = 1'b1;
        end else if (load_haz) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
        end
        stall_ev = load_haz && !ex_redirect;
    end

    always_comb begin
        slot_d = slot_q;
        for (int k = POST - 1; k >= 1; k--) begin
            slot_d[k] = slot_q[k-1];
        end
        slot_d[SLOT_EX]                 = '0;
        slot_d[SLOT_EX][F_VALID]        = id_valid && !bubble_ex;
        slot_d[SLOT_EX][F_REGWRITE]     = id_regwrite;
        slot_d[SLOT_EX][F_MEMREAD]      = id_memread;
        slot_d[SLOT_EX][F_USE_RS]       = id_use_rs;
        slot_d[SLOT_EX][F_USE_RT]       = id_use_rt;
        slot_d[SLOT_EX][F_DST +: AW]    = id_dst;
        slot_d[SLOT_EX][RS_L +: AW]     = id_rs;
        slot_d[SLOT_EX][RT_L +: AW]     = id_rt;

        stall_cnt_d = stall_cnt_q;
        if (stall_ev && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        flush_cnt_d = flush_cnt_q;
        if (ex_redirect && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            slot_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            slot_q      <= slot_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    fwd_match #(.AW(AW), .POST(POST), .LOAD_LAT(LOAD_LAT)) u_fwd_rs (
        .src_i      (slot_q[SLOT_EX][RS_L +: AW]),
        .src_en_i   (slot_q[SLOT_EX][F_VALID] && slot_q[SLOT_EX][F_USE_RS]),
        .valid_i    (sv_valid),
        .regwrite_i (sv_regwrite),
        .memread_i  (sv_memread),
        .dst_i      (sv_dst),
        .fwd_o      (fwd_a)
    );

    fwd_match #(.AW(AW), .POST(POST), .LOAD_LAT(LOAD_LAT)) u_fwd_rt (
        .src_i      (slot_q[SLOT_EX][RT_L +: AW]),
        .src_en_i   (slot_q[SLOT_EX][F_VALID] && slot_q[SLOT_EX][F_USE_RT]),
        .valid_i    (sv_valid),
        .regwrite_i (sv_regwrite),
        .memread_i  (sv_memread),
        .dst_i      (sv_dst),
        .fwd_o      (fwd_b)
    );

    assign slot_valid = sv_valid;
    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (default parameters, and
// POST=5/LOAD_LAT=2/CW=4) share one ID stream and are each compared every
// cycle with an instruction-list reference model.
module tb_pipe_hazard_ctrl;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       id_valid, id_use_rs, id_use_rt, id_regwrite, id_memread, ex_redirect;
    logic [4:0] id_rs, id_rt, id_dst;

    logic       d1_sif, d1_sid, d1_fl, d1_bub;
    logic [1:0] d1_fa, d1_fb;
    logic [2:0] d1_sv;
    logic [15:0] d1_sc, d1_fc;

    logic       d2_sif, d2_sid, d2_fl, d2_bub;
    logic [2:0] d2_fa, d2_fb;
    logic [4:0] d2_sv;
    logic [3:0] d2_sc, d2_fc;

    always #5 Clk = ~Clk;

    pipe_hazard_ctrl u_d1 (
        .Clk(Clk), .Reset(Reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .ex_redirect(ex_redirect),
        .stall_if(d1_sif), .stall_id(d1_sid), .flush_id(d1_fl), .bubble_ex(d1_bub),
        .fwd_a(d1_fa), .fwd_b(d1_fb), .slot_valid(d1_sv),
        .stall_cnt(d1_sc), .flush_cnt(d1_fc)
    );

    pipe_hazard_ctrl #(.AW(5), .POST(5), .LOAD_LAT(2), .CW(4)) u_d2 (
        .Clk(Clk), .Reset(Reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .ex_redirect(ex_redirect),
        .stall_if(d2_sif), .stall_id(d2_sid), .flush_id(d2_fl), .bubble_ex(d2_bub),
        .fwd_a(d2_fa), .fwd_b(d2_fb), .slot_valid(d2_sv),
        .stall_cnt(d2_sc), .flush_cnt(d2_fc)
    );

    // ---------------- reference model ----------------
    typedef struct {
        bit v;
        int rs, rt, dst;
        bit urs, urt, rw, mr;
    } ins_t;

    ins_t pipe [2][8];
    int   post_of [2] = '{3, 5};
    int   lat_of  [2] = '{1, 2};
    int   cmax_of [2] = '{65535, 15};
    int   scnt [2];
    int   fcnt [2];
    bit   exp_bub [2];
    bit   exp_sev [2];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic ins_t cur_id();
        ins_t r;
        r.v = id_valid; r.rs = int'(id_rs); r.rt = int'(id_rt); r.dst = int'(id_dst);
        r.urs = id_use_rs; r.urt = id_use_rt; r.rw = id_regwrite; r.mr = id_memread;
        return r;
    endfunction

    // ID reads a register that a load still in flight (age < LOAD_LAT) will write.
    function automatic bit model_hazard(input int m);
        ins_t id = cur_id();
        if (!id.v) return 1'b0;
        for (int j = 0; j < lat_of[m]; j++) begin
            ins_t p = pipe[m][j];
            if (p.v && p.mr && p.rw && p.dst != 0 &&
                ((id.urs && p.dst == id.rs) || (id.urt && p.dst == id.rt)))
                return 1'b1;
        end
        return 1'b0;
    endfunction

    // Youngest older instruction whose result is available and names the source.
    function automatic int model_fwd(input int m, input bit is_b);
        ins_t ex = pipe[m][0];
        int   src = is_b ? ex.rt : ex.rs;
        bit   use_src = is_b ? ex.urt : ex.urs;
        if (!(ex.v && use_src)) return 0;
        for (int k = 1; k < post_of[m]; k++) begin
            ins_t p = pipe[m][k];
            if (p.v && p.rw && p.dst != 0 && p.dst == src && (!p.mr || k >= lat_of[m]))
                return k;
        end
        return 0;
    endfunction

    task automatic check_dut(input int m,
                             input logic [31:0] sif, sid, fl, bub, fa, fb, sv, sc, fc);
        bit hz, red;
        int svexp;
        string n;
        n   = $sformatf("d%0d", m + 1);
        hz  = model_hazard(m);
        red = ex_redirect;
        exp_bub[m] = red || hz;
        exp_sev[m] = hz && !red;
        svexp = 0;
        for (int k = 0; k < post_of[m]; k++) if (pipe[m][k].v) svexp |= (1 << k);
        chk({n, " stall_if"},   sif, 32'(exp_sev[m]));
        chk({n, " stall_id"},   sid, 32'(exp_sev[m]));
        chk({n, " flush_id"},   fl,  32'(red));
        chk({n, " bubble_ex"},  bub, 32'(exp_bub[m]));
        chk({n, " fwd_a"},      fa,  32'(model_fwd(m, 1'b0)));
        chk({n, " fwd_b"},      fb,  32'(model_fwd(m, 1'b1)));
        chk({n, " slot_valid"}, sv,  32'(svexp));
        chk({n, " stall_cnt"},  sc,  32'(scnt[m]));
        chk({n, " flush_cnt"},  fc,  32'(fcnt[m]));
    endtask

    task automatic settle();
        #1;
        check_dut(0, 32'(d1_sif), 32'(d1_sid), 32'(d1_fl), 32'(d1_bub),
                  32'(d1_fa), 32'(d1_fb), 32'(d1_sv), 32'(d1_sc), 32'(d1_fc));
        check_dut(1, 32'(d2_sif), 32'(d2_sid), 32'(d2_fl), 32'(d2_bub),
                  32'(d2_fa), 32'(d2_fb), 32'(d2_sv), 32'(d2_sc), 32'(d2_fc));
    endtask

    task automatic clock_edge();
        @(posedge Clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            if (Reset) begin
                for (int k = 0; k < 8; k++) pipe[m][k].v = 1'b0;
                scnt[m] = 0;
                fcnt[m] = 0;
            end else begin
                for (int k = post_of[m] - 1; k >= 1; k--) pipe[m][k] = pipe[m][k-1];
                pipe[m][0]   = cur_id();
                pipe[m][0].v = id_valid && !exp_bub[m];
                if (exp_sev[m]) scnt[m] = (scnt[m] >= cmax_of[m]) ? cmax_of[m] : scnt[m] + 1;
                if (ex_redirect) fcnt[m] = (fcnt[m] >= cmax_of[m]) ? cmax_of[m] : fcnt[m] + 1;
            end
        end
    endtask

    task automatic step();
        settle();
        clock_edge();
    endtask

    task automatic drv(input bit v, input int rs, rt, input bit urs, urt,
                       input int dst, input bit rw, mr, red);
        id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_use_rs = urs; id_use_rt = urt;
        id_dst = 5'(dst); id_regwrite = rw; id_memread = mr; ex_redirect = red;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        Reset = 1'b0;
    endtask

    initial begin
        bit hold;
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 8; k++) pipe[m][k].v = 1'b0;
            scnt[m] = 0; fcnt[m] = 0; exp_bub[m] = 0; exp_sev[m] = 0;
        end
        Reset = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        clock_edge();
        do_reset();

        // lw r2 ; add r3,r2,r4 -> one stall (default), forward from slot 2 later
        drv(1, 1, 0, 1, 0, 2, 1, 1, 0); step();
        drv(1, 2, 4, 1, 1, 3, 1, 0, 0); settle();
        chk("loaduse stall_if", 32'(d1_sif), 1);
        chk("loaduse stall_id", 32'(d1_sid), 1);
        chk("loaduse bubble",   32'(d1_bub), 1);
        clock_edge();
        settle();
        chk("loaduse released", 32'(d1_sif), 0);
        chk("lat2 still stalls", 32'(d2_sif), 1);
        clock_edge();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0); settle();
        chk("loaduse fwd_a", 32'(d1_fa), 2);
        clock_edge();

        // sub r5 ; add r5 ; add r6,r5,r0 -> youngest producer wins, r0 never forwards
        do_reset();
        drv(1, 1, 1, 1, 1, 5, 1, 0, 0); step();
        drv(1, 1, 1, 1, 1, 5, 1, 0, 0); step();
        drv(1, 5, 0, 1, 1, 6, 1, 0, 0); settle();
        chk("alu chain no stall", 32'(d1_sif), 0);
        clock_edge();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0); settle();
        chk("youngest fwd_a d1", 32'(d1_fa), 1);
        chk("youngest fwd_a d2", 32'(d2_fa), 1);
        chk("r0 fwd_b", 32'(d1_fb), 0);
        clock_edge();

        // load hazard together with redirect: redirect wins
        do_reset();
        drv(1, 1, 0, 1, 0, 2, 1, 1, 0); step();
        drv(1, 2, 4, 1, 1, 3, 1, 0, 1); settle();
        chk("redir flush_id", 32'(d1_fl), 1);
        chk("redir bubble",   32'(d1_bub), 1);
        chk("redir stall_if", 32'(d1_sif), 0);
        clock_edge();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0); settle();
        chk("redir stall_cnt", 32'(d1_sc), 0);
        chk("redir flush_cnt", 32'(d1_fc), 1);
        clock_edge();

        // lw r0 ; use r0 twice -> neither stall nor forward
        do_reset();
        drv(1, 1, 0, 1, 0, 0, 1, 1, 0); step();
        drv(1, 0, 0, 1, 1, 7, 1, 0, 0); settle();
        chk("r0 no stall d1", 32'(d1_sif), 0);
        chk("r0 no stall d2", 32'(d2_sif), 0);
        clock_edge();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0); settle();
        chk("r0 fwd_a", 32'(d1_fa), 0);
        chk("r0 fwd_b2", 32'(d1_fb), 0);
        clock_edge();

        // chained lw r2,0(r2): the 4-bit counter of the LOAD_LAT=2 copy saturates
        do_reset();
        drv(1, 2, 0, 1, 0, 2, 1, 1, 0);
        repeat (36) step();
        settle();
        chk("stall_cnt saturates", 32'(d2_sc), 15);
        clock_edge();

        // reset landing on a stall cycle discards the hazard and the counters
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0); step(); step();
        drv(1, 1, 0, 1, 0, 2, 1, 1, 0); step();
        drv(1, 2, 4, 1, 1, 3, 1, 0, 0);
        Reset = 1'b1;
        settle();
        chk("pre-reset stall", 32'(d1_sif), 1);
        clock_edge();
        Reset = 1'b0;
        settle();
        chk("post-reset slot_valid", 32'(d1_sv), 0);
        chk("post-reset stall_cnt", 32'(d1_sc), 0);
        chk("post-reset stall_cnt d2", 32'(d2_sc), 0);
        chk("post-reset stall_if", 32'(d1_sif), 0);
        chk("post-reset bubble", 32'(d1_bub), 0);
        clock_edge();

        // randomized traffic over a small register set so hazards are frequent
        do_reset();
        hold = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if (!hold) begin
                id_valid    = ($urandom_range(0, 9) != 0);
                id_rs       = 5'($urandom_range(0, 3));
                id_rt       = 5'($urandom_range(0, 3));
                id_use_rs   = 1'($urandom_range(0, 1));
                id_use_rt   = 1'($urandom_range(0, 1));
                id_dst      = 5'($urandom_range(0, 3));
                id_regwrite = ($urandom_range(0, 4) != 0);
                id_memread  = 1'($urandom_range(0, 1));
            end
            ex_redirect = ($urandom_range(0, 9) == 0);
            Reset       = ($urandom_range(0, 79) == 0);
            settle();
            hold = exp_sev[0];
            clock_edge();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
